// File: rtl/number_pkg.sv
// Shared constants and FSM state encoding for the decimal number composer.
package number_pkg;

    localparam int unsigned DEC_BASE  = 10;
    localparam int unsigned DIGIT_MAX = 9;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ENTRY = 2'd1;
    localparam logic [1:0] ST_CALC  = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

endpackage

// File: rtl/number_compose_module_if.sv
// Digit input, control and result handshake bundle for number_compose_module.
interface number_compose_module_if #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned MAX_DIGITS = 5
);

    logic                                  Clear;
    logic                                  Digit_Valid;
    logic [3:0]                            Digit_Data;
    logic                                  Digit_Ready;
    logic                                  Enter;
    logic                                  Num_Valid;
    logic                                  Num_Ready;
    logic [WIDTH-1:0]                      Num_Data;
    logic [$clog2(MAX_DIGITS+1)-1:0]       Digit_Count;
    logic                                  Err;

    modport master (
        output Clear, Digit_Valid, Digit_Data, Enter, Num_Ready,
        input  Digit_Ready, Num_Valid, Num_Data, Digit_Count, Err
    );

    modport slave (
        input  Clear, Digit_Valid, Digit_Data, Enter, Num_Ready,
        output Digit_Ready, Num_Valid, Num_Data, Digit_Count, Err
    );

endinterface

// File: rtl/number_mul10_add.sv
// Combinational acc*10 + d with overflow detection, evaluated four bits wider than acc.
module number_mul10_add
    import number_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [3:0]       d_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             ovf_o
);

    localparam int unsigned WW = WIDTH + 4;

    logic [WW-1:0] wide;

    // acc*10+9 < 16*2^WIDTH, so four extra bits never wrap
    always_comb begin
        wide  = ({4'b0000, acc_i} * WW'(DEC_BASE)) + WW'(d_i);
        sum_o = wide[WIDTH-1:0];
        ovf_o = |wide[WW-1:WIDTH];
    end

endmodule

// File: rtl/number_compose_module.sv
// Composes a binary number from a stream of decimal digits, MSD first, with
// commit/clear control and a valid/ready result handshake.
module number_compose_module
    import number_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned MAX_DIGITS = 5
) (
    input  logic                   CLK,
    input  logic                   RST,
    number_compose_module_if.slave bus
);

    localparam int unsigned CW = $clog2(MAX_DIGITS + 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       dig_q, dig_d;
    logic             err_q, err_d;
    logic             pend_q, pend_d;

    logic [WIDTH-1:0] mac_sum;
    logic             mac_ovf;
    logic             digit_ready;
    logic             accept;
    logic             digit_ok;

    number_mul10_add #(
        .WIDTH (WIDTH)
    ) u_mul10_add (
        .acc_i (acc_q),
        .d_i   (dig_q),
        .sum_o (mac_sum),
        .ovf_o (mac_ovf)
    );

    assign digit_ready = !RST && ((state_q == ST_IDLE) || (state_q == ST_ENTRY)) &&
                         (cnt_q < CW'(MAX_DIGITS));
    assign accept      = bus.Digit_Valid && digit_ready;
    assign digit_ok    = (bus.Digit_Data <= 4'(DIGIT_MAX));

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        dig_d   = dig_q;
        err_d   = err_q;
        pend_d  = pend_q;
        if (bus.Clear) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_ENTRY: begin
                    if (accept && digit_ok) begin
                        dig_d   = bus.Digit_Data;
                        pend_d  = bus.Enter;
                        state_d = ST_CALC;
                    end else begin
                        // a rejected (non-decimal) digit flags Err but never blocks a commit
                        if (accept) err_d = 1'b1;
                        if (bus.Enter) state_d = ST_OUT;
                    end
                end
                ST_CALC: begin
                    if (mac_ovf) begin
                        err_d = 1'b1;
                    end else begin
                        acc_d = mac_sum;
                        cnt_d = cnt_q + CW'(1);
                    end
                    pend_d  = 1'b0;
                    state_d = pend_q ? ST_OUT : ST_ENTRY;
                end
                ST_OUT: begin
                    if (bus.Num_Ready) begin
                        state_d = ST_IDLE;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            dig_q   <= '0;
            err_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
        end
    end

    assign bus.Digit_Ready = digit_ready;
    assign bus.Num_Valid   = (state_q == ST_OUT);
    assign bus.Num_Data    = acc_q;
    assign bus.Digit_Count = cnt_q;
    assign bus.Err         = err_q;

endmodule

// File: tb/tb_number_compose_module.sv
// Self-checking bench: vector table, hand-written corner sequences and a random
// digit stream checked against an arithmetic reference model.
module tb_number_compose_module;

    localparam int unsigned WIDTH      = 16;
    localparam int unsigned MAX_DIGITS = 5;
    localparam longint      MAX_VAL    = (64'd1 << WIDTH) - 1;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    number_compose_module_if #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS)) bus ();

    number_compose_module #(
        .WIDTH      (WIDTH),
        .MAX_DIGITS (MAX_DIGITS)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Reference model state
    longint m_acc;
    int     m_cnt;
    bit     m_err;

    typedef struct {
        int unsigned ndig;
        logic [23:0] digs;   // hex nibbles, MSD first
        int unsigned exp_data;
        int unsigned exp_cnt;
        bit          exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.Clear       = 1'b0;
        bus.Digit_Valid = 1'b0;
        bus.Digit_Data  = 4'h0;
        bus.Enter       = 1'b0;
        bus.Num_Ready   = 1'b0;
    endtask

    task automatic do_clear();
        bus.Clear = 1'b1;
        tick();
        bus.Clear = 1'b0;
        m_acc = 0;
        m_cnt = 0;
        m_err = 1'b0;
    endtask

    function automatic void model_digit(input int d);
        if (d > 9) m_err = 1'b1;
        else if (m_acc * 10 + d > MAX_VAL) m_err = 1'b1;
        else begin
            m_acc = m_acc * 10 + d;
            m_cnt++;
        end
    endfunction

    // Offers one digit; without a coincident Enter, also waits out the update cycle
    task automatic send_digit(input logic [3:0] d, input bit enter);
        int n = 0;
        while (!bus.Digit_Ready && n < 8) begin
            tick();
            n++;
        end
        if (!bus.Digit_Ready) check("ready_timeout", 0, 1);
        bus.Digit_Valid = 1'b1;
        bus.Digit_Data  = d;
        bus.Enter       = enter;
        tick();
        bus.Digit_Valid = 1'b0;
        bus.Enter       = 1'b0;
        if (!enter) tick();
    endtask

    task automatic press_enter();
        bus.Enter = 1'b1;
        tick();
        bus.Enter = 1'b0;
    endtask

    task automatic expect_out(input string tag, input longint data, input int cnt, input bit err,
                              input int hold);
        int n = 0;
        while (!bus.Num_Valid && n < 8) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, bus.Num_Valid, 1);
        check({tag, "_data"}, bus.Num_Data, data);
        check({tag, "_cnt"}, bus.Digit_Count, cnt);
        check({tag, "_err"}, bus.Err, err);
        repeat (hold) tick();
        bus.Num_Ready = 1'b1;
        tick();
        bus.Num_Ready = 1'b0;
        check({tag, "_valid_drop"}, bus.Num_Valid, 0);
        check({tag, "_cnt_zero"}, bus.Digit_Count, 0);
        check({tag, "_err_kept"}, bus.Err, err);
    endtask

    initial begin
        logic [23:0] tmp;
        idle_inputs();
        m_acc = 0;
        m_cnt = 0;
        m_err = 1'b0;

        vecs[0] = '{4, 24'h1234,  1234,  4, 1'b0};
        vecs[1] = '{5, 24'h65536, 6553,  4, 1'b1};
        vecs[2] = '{2, 24'h0000A7, 7,    1, 1'b1};
        vecs[3] = '{0, 24'h0,     0,     0, 1'b0};
        vecs[4] = '{5, 24'h99999, 9999,  4, 1'b1};
        vecs[5] = '{5, 24'h65535, 65535, 5, 1'b0};
        vecs[6] = '{3, 24'h007,   7,     3, 1'b0};
        vecs[7] = '{5, 24'h12345, 12345, 5, 1'b0};

        // Reset state
        repeat (3) tick();
        check("rst_ready_low", bus.Digit_Ready, 0);
        RST = 1'b0;
        #1;
        check("rst_valid", bus.Num_Valid, 0);
        check("rst_data", bus.Num_Data, 0);
        check("rst_cnt", bus.Digit_Count, 0);
        check("rst_err", bus.Err, 0);
        check("idle_ready", bus.Digit_Ready, 1);

        // Vector table
        foreach (vecs[v]) begin
            do_clear();
            for (int i = 0; i < int'(vecs[v].ndig); i++) begin
                tmp = vecs[v].digs >> (4 * (vecs[v].ndig - 1 - i));
                send_digit(tmp[3:0], 1'b0);
            end
            press_enter();
            expect_out($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_cnt,
                       vecs[v].exp_err, v % 3);
        end

        // Non-decimal digit in IDLE
        do_clear();
        send_digit(4'hA, 1'b0);
        check("hexA_err", bus.Err, 1);
        check("hexA_cnt", bus.Digit_Count, 0);
        send_digit(4'd7, 1'b0);
        press_enter();
        expect_out("hexA_then7", 7, 1, 1'b1, 0);

        // Result held while Num_Ready low; offered digits ignored
        do_clear();
        press_enter();
        for (int i = 0; i < 10; i++) begin
            bus.Digit_Valid = 1'b1;
            bus.Digit_Data  = 4'd5;
            bus.Enter       = (i == 3);
            check("hold_valid", bus.Num_Valid, 1);
            check("hold_data", bus.Num_Data, 0);
            check("hold_ready", bus.Digit_Ready, 0);
            tick();
        end
        idle_inputs();
        expect_out("hold_end", 0, 0, 1'b0, 0);

        // Digit and Enter in the same cycle
        do_clear();
        send_digit(4'd9, 1'b1);
        check("coinc_calc_valid", bus.Num_Valid, 0);
        check("coinc_calc_ready", bus.Digit_Ready, 0);
        tick();
        check("coinc_out_valid", bus.Num_Valid, 1);
        expect_out("coinc", 9, 1, 1'b0, 0);

        // Clear during the update cycle, then reset during OUT
        do_clear();
        send_digit(4'd4, 1'b0);
        check("ready_back", bus.Digit_Ready, 1);
        bus.Digit_Valid = 1'b1;
        bus.Digit_Data  = 4'd2;
        tick();
        bus.Digit_Valid = 1'b0;
        check("calc_ready_low", bus.Digit_Ready, 0);
        bus.Clear = 1'b1;
        tick();
        bus.Clear = 1'b0;
        check("clr_cnt", bus.Digit_Count, 0);
        check("clr_acc", bus.Num_Data, 0);
        check("clr_idle_ready", bus.Digit_Ready, 1);
        press_enter();
        expect_out("clr_enter", 0, 0, 1'b0, 0);
        send_digit(4'd3, 1'b0);
        press_enter();
        check("pre_rst_valid", bus.Num_Valid, 1);
        RST = 1'b1;
        #1;
        check("rst_comb_ready", bus.Digit_Ready, 0);
        tick();
        RST = 1'b0;
        check("rst_out_valid", bus.Num_Valid, 0);
        check("rst_out_cnt", bus.Digit_Count, 0);
        check("rst_out_data", bus.Num_Data, 0);

        // Random digit streams against the reference model
        for (int it = 0; it < 40; it++) begin
            int  nd;
            bit  coinc;
            int  d;
            do_clear();
            nd    = $urandom_range(0, 7);
            coinc = 1'b0;
            for (int i = 0; i < nd; i++) begin
                if (m_cnt >= MAX_DIGITS) break;
                if ($urandom_range(0, 4) == 0) d = $urandom_range(10, 15);
                else d = $urandom_range(0, 9);
                coinc = (i == nd - 1) && (d <= 9) && ($urandom_range(0, 1) == 1);
                send_digit(4'(d), coinc);
                model_digit(d);
                if (!coinc) begin
                    check("rnd_cnt", bus.Digit_Count, m_cnt);
                    check("rnd_err", bus.Err, m_err);
                end
            end
            if (!coinc) press_enter();
            expect_out("rnd", m_acc, m_cnt, m_err, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
